// File: rtl/fpga2ar9331_burst_tx.sv
// FPGA->AR9331 parallel burst transmitter: FIFO-sourced words, toggle
// strobe/ack handshake, per-word ack timeout and explicit bus enable.
module fpga2ar9331_burst_tx #(
  parameter int DATA_W   = 8,
  parameter int LEN_W    = 8,
  parameter int SYNC_STG = 2,
  parameter int GUARD    = 2,
  parameter int TIMEOUT  = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_o,
  input  logic [DATA_W-1:0] fifo_data_i,
  input  logic              ack_i,
  output logic              strb_o,
  output logic [DATA_W-1:0] data_out_o,
  output logic              data_oe_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_err_o
);

  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_WAIT, S_GUARD, S_ERR
  } state_e;

  state_e              state_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [LEN_W-1:0]    cnt_d;
  logic [TMO_W-1:0]    tmo_q;
  logic [TMO_W-1:0]    tmo_d;
  logic [3:0]          gcnt_q;
  logic [SYNC_STG-1:0] sync_q;
  logic                ack_prev_q;
  logic                strb_q;
  logic [DATA_W-1:0]   data_q;
  logic                oe_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic ack_s;
  logic ack_evt;
  logic tmo_hit;
  logic g_last;

  assign ack_s   = sync_q[SYNC_STG-1];
  assign ack_evt = ack_s ^ ack_prev_q;
  assign cnt_d   = cnt_q - 1'b1;
  assign tmo_d   = tmo_q + 1'b1;
  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign g_last  = (gcnt_q == 4'(GUARD - 1));

  // Pop is combinational so the word is ready for capture in LOAD
  assign fifo_rd_o = (state_q == S_FETCH) && !fifo_empty_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tmo_q      <= '0;
      gcnt_q     <= '0;
      sync_q     <= '0;
      ack_prev_q <= 1'b0;
      strb_q     <= 1'b0;
      data_q     <= '0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], ack_i};
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i && (len_i != '0)) begin
            cnt_q      <= len_i;
            oe_q       <= 1'b1;
            strb_q     <= 1'b0;
            busy_q     <= 1'b1;
            ack_prev_q <= ack_s;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!fifo_empty_i) state_q <= S_LOAD;
        end
        S_LOAD: begin
          data_q  <= fifo_data_i;
          strb_q  <= ~strb_q;
          cnt_q   <= cnt_d;
          tmo_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (ack_evt) begin
            ack_prev_q <= ack_s;
            if (cnt_q != '0) begin
              state_q <= S_FETCH;
            end else if (GUARD == 0) begin
              oe_q    <= 1'b0;
              strb_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              oe_q    <= 1'b0;
              strb_q  <= 1'b0;
              gcnt_q  <= '0;
              state_q <= S_GUARD;
            end
          end else if (tmo_hit) begin
            oe_q    <= 1'b0;
            strb_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        S_GUARD: begin
          if (g_last) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gcnt_q <= gcnt_q + 1'b1;
          end
        end
        S_ERR: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign strb_o        = strb_q;
  assign data_out_o    = data_q;
  assign data_oe_o     = oe_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_fpga2ar9331_burst_tx.sv
// Directed bench for fpga2ar9331_burst_tx: two instances, one small with a
// short timeout and one wide running a full-length burst.
module tb_fpga2ar9331_burst_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // instance A: 8-bit, timeout 16
  logic        start_a = 1'b0;
  logic [7:0]  len_a   = '0;
  logic        rd_a, strb_a, oe_a, busy_a, done_a, err_a;
  logic [7:0]  fdata_a = '0;
  logic [7:0]  data_a;
  logic        ack_a   = 1'b0;
  logic [7:0]  mem_a [0:63];
  int          wp_a = 0;
  int          rp_a = 0;
  logic        empty_a;
  assign empty_a = (rp_a == wp_a);

  // instance B: 16-bit data, 10-bit length
  logic        start_b = 1'b0;
  logic [9:0]  len_b   = '0;
  logic        rd_b, strb_b, oe_b, busy_b, done_b, err_b;
  logic [15:0] fdata_b = '0;
  logic [15:0] data_b;
  logic        ack_b   = 1'b0;
  logic [15:0] mem_b [0:1023];
  int          wp_b = 0;
  int          rp_b = 0;
  logic        empty_b;
  assign empty_b = (rp_b == wp_b);

  fpga2ar9331_burst_tx #(
    .DATA_W(8), .LEN_W(8), .SYNC_STG(2), .GUARD(2), .TIMEOUT(16)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .len_i(len_a),
    .fifo_empty_i(empty_a), .fifo_rd_o(rd_a), .fifo_data_i(fdata_a),
    .ack_i(ack_a), .strb_o(strb_a), .data_out_o(data_a),
    .data_oe_o(oe_a), .busy_o(busy_a), .done_o(done_a),
    .timeout_err_o(err_a)
  );

  fpga2ar9331_burst_tx #(
    .DATA_W(16), .LEN_W(10), .SYNC_STG(2), .GUARD(2), .TIMEOUT(4096)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .len_i(len_b),
    .fifo_empty_i(empty_b), .fifo_rd_o(rd_b), .fifo_data_i(fdata_b),
    .ack_i(ack_b), .strb_o(strb_b), .data_out_o(data_b),
    .data_oe_o(oe_b), .busy_o(busy_b), .done_o(done_b),
    .timeout_err_o(err_b)
  );

  // FIFO models: data valid the cycle after the pop
  always @(posedge clk) begin
    if (rd_a && !empty_a) begin
      fdata_a <= mem_a[rp_a];
      rp_a    <= rp_a + 1;
    end
    if (rd_b && !empty_b) begin
      fdata_b <= mem_b[rp_b];
      rp_b    <= rp_b + 1;
    end
  end

  // Host A: monitor plus ack 4 cycles after each strobe edge, up to budget
  int         cyc_a = 0, cd_a = 0, acked_a = 0, budget_a = 0;
  int         tog_a = 0, rdn_a = 0, donen_a = 0, errn_a = 0;
  int         tog_cyc_a = 0, err_cyc_a = 0;
  logic       sp_a = 1'b0;
  logic [7:0] recv_a [0:63];

  always @(negedge clk) begin
    cyc_a++;
    if (cd_a > 0) begin
      cd_a--;
      if (cd_a == 0) ack_a = ~ack_a;
    end
    if (rd_a) rdn_a++;
    if (done_a) donen_a++;
    if (err_a) begin
      errn_a++;
      err_cyc_a = cyc_a;
    end
    if (oe_a && strb_a !== sp_a) begin
      if (tog_a < 64) recv_a[tog_a] = data_a;
      tog_a++;
      tog_cyc_a = cyc_a;
      if (acked_a < budget_a) begin
        acked_a++;
        cd_a = 4;
      end
    end
    sp_a = strb_a;
  end

  // Host B: random ack delay 1..40
  int          cd_b = 0, tog_b = 0, rdn_b = 0, donen_b = 0, errn_b = 0;
  logic        sp_b = 1'b0;
  logic [15:0] recv_b [0:1023];

  always @(negedge clk) begin
    if (cd_b > 0) begin
      cd_b--;
      if (cd_b == 0) ack_b = ~ack_b;
    end
    if (rd_b) rdn_b++;
    if (done_b) donen_b++;
    if (err_b) errn_b++;
    if (oe_b && strb_b !== sp_b) begin
      if (tog_b < 1024) recv_b[tog_b] = data_b;
      tog_b++;
      cd_b = int'($urandom_range(40, 1));
    end
    sp_b = strb_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int   b_tog, b_rd, b_done, b_err, bad;
  logic act;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {26'd0, strb_a, oe_a, busy_a, done_a, err_a, rd_a}, 0);
    chk("rst_data", {24'd0, data_a}, 0);
    chk("rst_b", {15'd0, strb_b, oe_b, busy_b, done_b, err_b, data_b}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: six-word burst 0..5
    for (int i = 0; i < 6; i++) mem_a[wp_a + i] = 8'(i);
    wp_a     = wp_a + 6;
    budget_a = acked_a + 6;
    b_tog = tog_a; b_rd = rdn_a; b_done = donen_a;
    start_a = 1'b1; len_a = 8'd6;
    @(negedge clk);
    start_a = 1'b0;
    chk("t1_busy_fetch", {30'd0, busy_a, rd_a}, 32'h3);
    @(negedge clk);
    chk("t1_load", {30'd0, strb_a, rd_a}, 0);
    @(negedge clk);
    chk("t1_first_strb", {23'd0, strb_a, data_a}, 32'h100);
    for (int i = 0; i < 400 && busy_a; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("t1_busy_low", {31'd0, busy_a}, 0);
    chk("t1_toggles", tog_a - b_tog, 6);
    chk("t1_fifo_rd", rdn_a - b_rd, 6);
    chk("t1_done", donen_a - b_done, 1);
    bad = 0;
    for (int i = 0; i < 6; i++)
      if (recv_a[b_tog + i] !== 8'(i)) bad++;
    chk("t1_data_order", bad, 0);
    chk("t1_oe_off", {30'd0, oe_a, strb_a}, 0);

    // 2: zero length is ignored
    b_rd = rdn_a; b_done = donen_a;
    start_a = 1'b1; len_a = 8'd0;
    @(negedge clk);
    start_a = 1'b0;
    act = 1'b0;
    for (int i = 0; i < 10; i++) begin
      act = act | busy_a | strb_a | rd_a | done_a | oe_a;
      @(negedge clk);
    end
    chk("t2_len0_quiet", {31'd0, act}, 0);
    chk("t2_len0_counts", (rdn_a - b_rd) + (donen_a - b_done), 0);

    // 3: FIFO empty for 20 cycles, then one word
    b_tog = tog_a; b_rd = rdn_a; b_done = donen_a;
    budget_a = acked_a + 1;
    start_a = 1'b1; len_a = 8'd1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (20) @(negedge clk);
    chk("t3_wait_empty", {rdn_a - b_rd}, 0);
    chk("t3_still_busy", {30'd0, busy_a, strb_a}, 32'h2);
    mem_a[wp_a] = 8'hA5;
    wp_a = wp_a + 1;
    for (int i = 0; i < 200 && busy_a; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("t3_fifo_rd", rdn_a - b_rd, 1);
    chk("t3_toggles", tog_a - b_tog, 1);
    chk("t3_data", {24'd0, recv_a[b_tog]}, 32'hA5);
    chk("t3_done", donen_a - b_done, 1);

    // 4: only word 1 acked -> timeout after word 2
    mem_a[wp_a] = 8'h31; mem_a[wp_a + 1] = 8'h32; mem_a[wp_a + 2] = 8'h33;
    wp_a = wp_a + 3;
    budget_a = acked_a + 1;
    b_tog = tog_a; b_rd = rdn_a; b_done = donen_a; b_err = errn_a;
    start_a = 1'b1; len_a = 8'd3;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 200 && !err_a; i++) @(negedge clk);
    chk("t4_err_pulse", {30'd0, err_a, oe_a}, 32'h2);
    @(negedge clk);
    chk("t4_err_1cyc", {30'd0, err_a, busy_a}, 0);
    repeat (3) @(negedge clk);
    chk("t4_err_delay", err_cyc_a - tog_cyc_a, 16);
    chk("t4_toggles", tog_a - b_tog, 2);
    chk("t4_fifo_rd", rdn_a - b_rd, 2);
    chk("t4_no_done", donen_a - b_done, 0);
    chk("t4_err_count", errn_a - b_err, 1);

    // 5: reset while waiting on word 2 of 4 (0x33 still queued)
    for (int i = 0; i < 4; i++) mem_a[wp_a + i] = 8'h51 + 8'(i);
    wp_a = wp_a + 4;
    budget_a = acked_a + 1;
    b_tog = tog_a; b_rd = rdn_a; b_done = donen_a; b_err = errn_a;
    start_a = 1'b1; len_a = 8'd4;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 200 && (tog_a - b_tog) < 2; i++) @(negedge clk);
    chk("t5_word2_data", {24'd0, data_a}, 32'h51);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_ctrl", {26'd0, strb_a, oe_a, busy_a, done_a, err_a, rd_a}, 0);
    chk("t5_rst_data", {24'd0, data_a}, 0);
    repeat (20) @(negedge clk);
    chk("t5_no_pulses", (donen_a - b_done) + (errn_a - b_err), 0);
    chk("t5_fifo_rd", rdn_a - b_rd, 2);
    b_tog = tog_a; b_rd = rdn_a; b_done = donen_a;
    budget_a = acked_a + 3;
    start_a = 1'b1; len_a = 8'd3;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 300 && busy_a; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("t5_restart_done", donen_a - b_done, 1);
    chk("t5_restart_rd", rdn_a - b_rd, 3);
    chk("t5_restart_data",
        {8'd0, recv_a[b_tog], recv_a[b_tog + 1], recv_a[b_tog + 2]},
        32'h00525354);

    // 6: wide instance, maximum length 1023, random ack delays
    for (int i = 0; i < 1023; i++) mem_b[i] = 16'($urandom);
    wp_b = 1023;
    start_b = 1'b1; len_b = 10'd1023;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 60000 && busy_b; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("t6_busy_low", {31'd0, busy_b}, 0);
    chk("t6_toggles", tog_b, 1023);
    chk("t6_parity", tog_b & 1, 1);
    chk("t6_fifo_rd", rdn_b, 1023);
    chk("t6_done", donen_b, 1);
    chk("t6_no_err", errn_b, 0);
    bad = 0;
    for (int i = 0; i < 1023; i++)
      if (recv_b[i] !== mem_b[i]) bad++;
    chk("t6_data_order", bad, 0);
    chk("t6_bus_off", {30'd0, oe_b, strb_b}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
